uart_stim_tx: RTL and testbench

- Parametrised UART transmitter with an input byte FIFO.
- Replaces the constant-high tie-off on the SoC UART receive inputs (isp_uart_rx, user_uart_rx) in system-level simulation, so the bench can stream ISP command bytes or user console input into soc_top.
- Frame format and baud divisor are set by parameters.
- Written synthesizable so it can also be reused as an on-chip debug transmitter.

---
 rtl/uart_stim_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_stim_tx.sv | 134 +++++++++++++
 tb/tb_uart_stim_tx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_stim_pkg.sv
// rtl/uart_stim_pkg.sv - shared types and helpers for the UART stimulus transmitter
// Purpose: parity mode and FSM state encodings, default baud divisor, parity helper.
// Ports: none (package).
package uart_stim_pkg;

  // 115200 baud from a 50 MHz clock.
  localparam int UART_DIV_115200 = 434;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Parity over the low nbits of data; even parity is the plain XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int nbits, input parity_t mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) x = x ^ data[i];
    end
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parametrised synchronous FIFO with drop-on-full
// Purpose: byte queue in front of the UART FSM; show-ahead read (rd_data is the head).
// Ports: clk, rst (sync, active-high); wr_en/wr_data push; rd_en pop; rd_data head entry;
//        full, empty, count occupancy; overflow sticky on write-while-full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && full) overflow <= 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_stim_tx.sv
// rtl/uart_stim_tx.sv - parametrised UART transmitter with input byte FIFO
// Purpose: serialises queued bytes as start/data/parity/stop frames on tx.
// Ports: clk, rst (sync, active-high); wr_en/wr_data push a byte; full, empty, count,
//        overflow FIFO status; busy frame in progress; frame_done pulse on last stop cycle;
//        tx serial line (idle high).
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLK_DIV    = UART_DIV_115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [7:0]                      wr_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            tx
);

  localparam parity_t     PAR_MODE  = parity_t'(2'(PARITY));
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_t   state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par_bit;
  logic [7:0]  fifo_data;
  logic        bit_end;
  logic        last_stop;
  logic        pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign last_stop  = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  // Popping on the last stop cycle lets the next frame start with no idle gap.
  assign pop        = !empty && ((state == IDLE) || last_stop);
  assign frame_done = last_stop;
  assign busy       = (state != IDLE);

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      PAR:     tx = par_bit;
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
    end else begin
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 16'd1;

      if (pop) begin
        shift   <= fifo_data;
        par_bit <= parity_bit(fifo_data, DATA_BITS, PAR_MODE);
      end

      case (state)
        IDLE: begin
          if (pop) state <= START;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= {1'b0, shift[7:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PAR_MODE != PAR_NONE) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= pop ? START : IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// tb/tb_uart_stim_tx.sv - scoreboard bench for uart_stim_tx across four frame formats
module tb_uart_stim_tx;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] wr_en;
  logic [7:0] wr_data;
  logic [3:0] tx_w, busy_w, fd_w, full_w, empty_w, ovf_w;
  logic [2:0] cnt_w [4];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          dut;
    logic [11:0] bits;   // bit k = k-th transmitted bit (start first)
    int          start;  // expected start cycle, -1 = don't care
    bit          b2b;    // must follow the previous frame with no gap
  } exp_t;

  exp_t exp_q[$];
  int   last_end [4];

  // dut0: 8N1, dut1: 8E1, dut2: 8O1, dut3: 7N2
  uart_stim_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data), .full(full_w[0]),
    .empty(empty_w[0]), .count(cnt_w[0]), .overflow(ovf_w[0]), .busy(busy_w[0]),
    .frame_done(fd_w[0]), .tx(tx_w[0]));
  uart_stim_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data), .full(full_w[1]),
    .empty(empty_w[1]), .count(cnt_w[1]), .overflow(ovf_w[1]), .busy(busy_w[1]),
    .frame_done(fd_w[1]), .tx(tx_w[1]));
  uart_stim_tx #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data), .full(full_w[2]),
    .empty(empty_w[2]), .count(cnt_w[2]), .overflow(ovf_w[2]), .busy(busy_w[2]),
    .frame_done(fd_w[2]), .tx(tx_w[2]));
  uart_stim_tx #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_data(wr_data), .full(full_w[3]),
    .empty(empty_w[3]), .count(cnt_w[3]), .overflow(ovf_w[3]), .busy(busy_w[3]),
    .frame_done(fd_w[3]), .tx(tx_w[3]));

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int d, input logic [11:0] b, input int s, input bit bb);
    exp_t e;
    e.dut = d; e.bits = b; e.start = s; e.b2b = bb;
    exp_q.push_back(e);
  endfunction

  // Decodes one DUT's tx line: mid-bit samples form the frame word; also checks
  // bit stability, busy throughout and frame_done only on the final cycle.
  task automatic mon(input int d, input int nb);
    exp_t        e;
    logic [11:0] obs;
    logic        first;
    bit          stable, fd_ok, busy_ok, aborted;
    int          start;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx_w[d] == 1'b0) begin
        start = cyc; obs = '0; stable = 1; fd_ok = 1; busy_ok = 1; aborted = 0; first = 1'b0;
        for (int k = 0; k < nb * DIV; k++) begin
          if (k != 0) @(negedge clk);
          if (rst) begin aborted = 1; break; end
          if (k % DIV == 0) first = tx_w[d];
          else if (tx_w[d] !== first) stable = 0;
          if (k % DIV == DIV / 2) obs[k / DIV] = tx_w[d];
          if (fd_w[d] !== ((k == nb * DIV - 1) ? 1'b1 : 1'b0)) fd_ok = 0;
          if (busy_w[d] !== 1'b1) busy_ok = 0;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_dut", d, e.dut);
            chk("frame_bits", int'(obs), int'(e.bits));
            if (e.start >= 0) chk("frame_start", start, e.start);
            if (e.b2b) chk("frame_gap", start - last_end[d], 1);
            chk("bit_stable", int'(stable), 1);
            chk("frame_done_pos", int'(fd_ok), 1);
            chk("busy_in_frame", int'(busy_ok), 1);
          end
          last_end[d] = cyc;
        end
      end
    end
  endtask

  initial mon(0, 10);
  initial mon(1, 11);
  initial mon(2, 11);
  initial mon(3, 10);

  // Single write into an idle DUT; the start bit is due two cycles later.
  task automatic wr1(input int d, input logic [7:0] v, input logic [11:0] bits);
    @(negedge clk);
    push(d, bits, cyc + 2, 1'b0);
    wr_en[d] = 1'b1;
    wr_data  = v;
    @(negedge clk);
    wr_en[d] = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  logic [11:0] fifo_bits [4];
  logic [7:0]  rst_bytes [3];
  int          t0;

  initial begin
    // {stop, data, start} frames for 0x01..0x04, 8N1
    fifo_bits[0] = 12'h202; fifo_bits[1] = 12'h204;
    fifo_bits[2] = 12'h206; fifo_bits[3] = 12'h208;
    rst_bytes[0] = 8'h11; rst_bytes[1] = 8'h22; rst_bytes[2] = 8'h33;
    for (int i = 0; i < 4; i++) last_end[i] = -100;

    rst = 1'b1; wr_en = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", tx_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_frame_done", fd_w[0], 0);
    chk("rst_overflow", ovf_w[0], 0);
    chk("rst_empty", empty_w[0], 1);
    chk("rst_full", full_w[0], 0);
    chk("rst_count", cnt_w[0], 0);
    mon_en = 1'b1;

    // 8N1 0x55: 0,1,0,1,0,1,0,1,0,1
    wr1(0, 8'h55, 12'h2AA);
    drain(200);
    chk("idle_busy", busy_w[0], 0);
    chk("idle_tx", tx_w[0], 1);

    // 8E1 0x07: three ones -> parity 1
    wr1(1, 8'h07, 12'h60E);
    drain(200);
    // 8O1 0x07: parity 0
    wr1(2, 8'h07, 12'h40E);
    drain(200);
    // 7N2 0xFF: seven ones, bit 7 dropped, two stop bits
    wr1(3, 8'hFF, 12'h3FE);
    drain(200);

    // FIFO full while a frame is in flight, so nothing pops during the burst
    wr1(0, 8'h55, 12'h2AA);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push(0, fifo_bits[i], -1, 1'b1);
      if (i == 4) begin
        chk("full_after_4", full_w[0], 1);
        chk("count_after_4", cnt_w[0], 4);
      end
      wr_en[0] = 1'b1;
      wr_data  = 8'(i + 1);
      @(negedge clk);
    end
    wr_en[0] = 1'b0;
    chk("overflow_set", ovf_w[0], 1);
    chk("count_after_drop", cnt_w[0], 4);
    drain(400);
    chk("overflow_sticky", ovf_w[0], 1);

    // Reset during the third data bit with two bytes queued
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      wr_en[0] = 1'b1;
      wr_data  = rst_bytes[i];
      @(negedge clk);
    end
    wr_en[0] = 1'b0;
    while (cyc < t0 + 15) @(negedge clk);
    chk("queued_before_rst", cnt_w[0], 2);
    chk("busy_before_rst", busy_w[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", tx_w[0], 1);
    chk("rst_mid_busy", busy_w[0], 0);
    chk("rst_mid_count", cnt_w[0], 0);
    chk("rst_mid_empty", empty_w[0], 1);
    chk("rst_mid_overflow", ovf_w[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // 0xA3 after reset
    wr1(0, 8'hA3, 12'h346);
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
